// File: rtl/unum4_mul_shiftadd.sv
`default_nettype none
// ============================================================================
// Module   : unum4_mul_shiftadd
// Purpose  : Iterative shift-add integer multiplier producing the full
//            2*DATA_W-bit product of two DATA_W-bit operands, signed or
//            unsigned. Magnitudes are multiplied one partial product per
//            cycle, and the sign is applied in a final negation step.
//            Uses the same en/done launch protocol as the shift-subtract
//            divider.
// Ports    : clk        - system clock, rising-edge active
//            rst        - synchronous active-high reset (wins over en)
//            en         - run request; hold high for the whole operation,
//                         low clears and idles the unit
//            sign       - 1 = two's-complement operands, 0 = unsigned
//                         (sampled at load only)
//            op_a       - multiplicand (sampled at load only)
//            op_b       - multiplier   (sampled at load only)
//            done       - product valid, registered
//            product_hi - upper DATA_W bits of the product
//            product_lo - lower DATA_W bits of the product
// Revision : 1.0 - initial release
// ============================================================================
module unum4_mul_shiftadd #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sign,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              done,
    output logic [DATA_W-1:0] product_hi,
    output logic [DATA_W-1:0] product_lo
);

    // Step counter must reach DATA_W+2 (finish state).
    localparam int PC_W  = $clog2(DATA_W + 3) + 1;
    localparam int ACC_W = 2 * DATA_W + 1;

    localparam logic [PC_W-1:0] C_PC_LOAD   = '0;
    localparam logic [PC_W-1:0] C_PC_LAST   = PC_W'(DATA_W);
    localparam logic [PC_W-1:0] C_PC_FIX    = PC_W'(DATA_W + 1);
    localparam logic [PC_W-1:0] C_PC_FINISH = PC_W'(DATA_W + 2);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [PC_W-1:0]   pc_q,    pc_d;
    logic [ACC_W-1:0]  acc_q,   acc_d;     // {carry, upper half, lower half}
    logic [DATA_W-1:0] mcand_q, mcand_d;   // multiplicand magnitude
    logic              a_neg_q, a_neg_d;
    logic              b_neg_q, b_neg_d;
    logic              done_q,  done_d;

    // Magnitude of a two's-complement value. The most negative value maps to
    // itself, which read as unsigned is exactly 2^(DATA_W-1) - the correct
    // magnitude, so no saturation is needed.
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? -x : x;
    endfunction

    // Partial-product add on the upper half; one bit wider to catch carry.
    logic [DATA_W:0] w_sum;

    always_comb begin
        w_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]}
              + (acc_q[0] ? {1'b0, mcand_q} : {(DATA_W + 1){1'b0}});
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        pc_d    = pc_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        done_d  = done_q;

        if (!en) begin
            // Dropping en aborts and clears, exactly like reset.
            pc_d   = '0;
            acc_d  = '0;
            done_d = 1'b0;
        end else if (pc_q == C_PC_LOAD) begin
            if (sign) begin
                a_neg_d = op_a[DATA_W-1];
                b_neg_d = op_b[DATA_W-1];
                mcand_d = mag(op_a);
                acc_d   = {1'b0, {DATA_W{1'b0}}, mag(op_b)};
            end else begin
                a_neg_d = 1'b0;
                b_neg_d = 1'b0;
                mcand_d = op_a;
                acc_d   = {1'b0, {DATA_W{1'b0}}, op_b};
            end
            pc_d = pc_q + PC_W'(1);
        end else if (pc_q <= C_PC_LAST) begin
            // Multiplier bits are consumed from acc[0] while the growing
            // product shifts in from the top, sharing one register.
            acc_d = {1'b0, w_sum, acc_q[DATA_W-1:1]};
            pc_d  = pc_q + PC_W'(1);
        end else if (pc_q == C_PC_FIX) begin
            if (a_neg_q ^ b_neg_q) begin
                acc_d[2*DATA_W-1:0] = -acc_q[2*DATA_W-1:0];
            end
            pc_d = pc_q + PC_W'(1);
        end else if (pc_q == C_PC_FINISH) begin
            // Terminal hold: product is stable until en drops.
            done_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign done       = done_q;
    assign product_hi = acc_q[2*DATA_W-1:DATA_W];
    assign product_lo = acc_q[DATA_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_unum4_mul_shiftadd.sv
`default_nettype none
// ============================================================================
// Module   : tb_unum4_mul_shiftadd
// Purpose  : Self-checking bench for unum4_mul_shiftadd. A behavioural model
//            (edge counter plus plain 64-bit multiply) predicts done and the
//            product every cycle; directed cases pin literal results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unum4_mul_shiftadd;

    localparam int W       = 32;
    localparam int LATENCY = W + 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         sign;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         done;
    logic [W-1:0] product_hi;
    logic [W-1:0] product_lo;

    int checks = 0;
    int errors = 0;

    unum4_mul_shiftadd #(.DATA_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sign       (sign),
        .op_a       (op_a),
        .op_b       (op_b),
        .done       (done),
        .product_hi (product_hi),
        .product_lo (product_lo)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference arithmetic
    // ------------------------------------------------------------------------
    function automatic logic [2*W-1:0] ref_mul(input logic s,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        logic signed [2*W-1:0] sp;
        if (s) begin
            sa = {{W{a[W-1]}}, a};
            sb = {{W{b[W-1]}}, b};
            sp = sa * sb;
            return sp;
        end
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    task automatic check(input string name, input logic [2*W-1:0] act,
                         input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Cycle model: counts consecutive enabled edges, captures the operands on
    // the first one.
    // ------------------------------------------------------------------------
    int             m_cnt = 0;
    logic [2*W-1:0] m_exp = '0;
    bit             mon_on = 1'b0;

    always @(posedge clk) begin
        if (rst || !en) begin
            m_cnt = 0;
        end else begin
            if (m_cnt == 0) m_exp = ref_mul(sign, op_a, op_b);
            if (m_cnt < LATENCY) m_cnt++;
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            check("mon_done", {{(2*W-1){1'b0}}, done},
                  {{(2*W-1){1'b0}}, (m_cnt >= LATENCY)});
            if (m_cnt >= LATENCY)
                check("mon_product", {product_hi, product_lo}, m_exp);
            else if (m_cnt == 0)
                check("mon_cleared", {product_hi, product_lo}, '0);
        end
    end

    // ------------------------------------------------------------------------
    // Runs from a negedge where inputs are already set and en=1: verifies done
    // rises exactly on edge LATENCY, then holds for 'hold' more cycles.
    // ------------------------------------------------------------------------
    task automatic wait_done(input string name, input logic [2*W-1:0] exp,
                             input bit scramble, input int hold);
        for (int e = 1; e <= LATENCY; e++) begin
            @(posedge clk);
            #1;
            if (scramble) begin
                op_a = $urandom;
                op_b = $urandom;
                sign = 1'($urandom);
            end
            if (e == LATENCY - 1)
                check({name, "_early"}, {{(2*W-1){1'b0}}, done}, '0);
        end
        check({name, "_done"}, {{(2*W-1){1'b0}}, done}, 1);
        check(name, {product_hi, product_lo}, exp);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check({name, "_hold_done"}, {{(2*W-1){1'b0}}, done}, 1);
            check({name, "_hold"}, {product_hi, product_lo}, exp);
        end
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic run(input string name, input logic s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [2*W-1:0] exp,
                       input bit scramble, input int hold);
        @(negedge clk);
        sign = s;
        op_a = a;
        op_b = b;
        en   = 1'b1;
        wait_done(name, exp, scramble, hold);
    endtask

    initial begin
        logic         rs;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst  = 1'b1;
        en   = 1'b0;
        sign = 1'b0;
        op_a = '0;
        op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_done", {{(2*W-1){1'b0}}, done}, '0);
        check("reset_product", {product_hi, product_lo}, '0);
        @(negedge clk);
        rst    = 1'b0;
        mon_on = 1'b1;

        // Pin the reference model against hand-computed values.
        check("model_uns", ref_mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF),
              64'hFFFF_FFFE_0000_0001);
        check("model_sgn", ref_mul(1'b1, 32'hFFFF_FFFD, 32'd7),
              64'hFFFF_FFFF_FFFF_FFEB);

        run("uns_full",   1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 0);
        run("sgn_mixed",  1'b1, 32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 0);
        run("sgn_swap",   1'b1, 32'd7,         32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 0);
        run("minneg_sq",  1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 0);
        run("minneg_m1",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 0);
        run("uns_corner", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 64'h7FFF_FFFF_8000_0000, 1'b0, 0);
        run("zero",       1'b1, 32'h0,         32'h8000_0000, 64'h0,                   1'b0, 0);
        run("scramble",   1'b1, 32'hFFFF_FFF0, 32'd1000,      64'hFFFF_FFFF_FFFF_C180, 1'b1, 0);

        // Abort after 12 enabled cycles.
        @(negedge clk);
        sign = 1'b0;
        op_a = 32'h1234_5678;
        op_b = 32'h9ABC_DEF0;
        en   = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        check("abort_done", {{(2*W-1){1'b0}}, done}, '0);
        check("abort_product", {product_hi, product_lo}, '0);
        run("relaunch", 1'b0, 32'd6, 32'd7, 64'h0000_0000_0000_002A, 1'b0, 0);

        // Reset pulse at pc=20, then a fresh run once reset releases.
        @(negedge clk);
        sign = 1'b1;
        op_a = 32'hDEAD_BEEF;
        op_b = 32'h0BAD_F00D;
        en   = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_done", {{(2*W-1){1'b0}}, done}, '0);
        check("rst_mid_product", {product_hi, product_lo}, '0);
        @(negedge clk);
        rst  = 1'b0;
        sign = 1'b0;
        op_a = 32'd100000;
        op_b = 32'd300000;
        wait_done("after_rst", 64'd30000000000, 1'b0, 0);

        // Hold after done.
        run("hold", 1'b1, 32'hFFFF_FF85, 32'h7FFF_FFFF, 64'hFFFF_FFC2_8000_007B, 1'b0, 10);

        // Randomised operands, biased toward corner values.
        for (int i = 0; i < 30; i++) begin
            rs = 1'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ra = 32'h8000_0000;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h0;
                default: ;
            endcase
            run("random", rs, ra, rb, ref_mul(rs, ra, rb), 1'($urandom), 0);
        end

        @(negedge clk);
        mon_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
